// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: 2-entry skid buffer between EX/MEM and CU/RU, one commit per cycle.
// Optional retire/trap counters are enabled with `define WB_PERF_CNT_EN.
module wb_commit_stage #(
   parameter int DW = 64,
   parameter int VW = 128,
   parameter int AW = 64,
   localparam int PW = 3*DW + VW + 2*AW + 111
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ex_valid,
   output logic          ex_ready,
   input  logic [PW-1:0] ex_pld,
   input  logic          hold,
   input  logic          int_req,
   input  logic          pip_flush,
   output logic          wb_valid,
   output logic [PW-1:0] wb_pld,
`ifdef WB_PERF_CNT_EN
   output logic [63:0]   retire_cnt,
   output logic [63:0]   trap_cnt,
`endif
   output logic          int_acc
);

   localparam int EXC_LO  = 0;
   localparam int FLOW_LO = 10;
   localparam int CTRL_W  = 20;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t        state_reg;
   state_t        state_next;
   logic          ex_ready_reg;
   logic [PW-1:0] main_reg;
   logic [PW-1:0] skid_reg;

   logic          accept;
   logic          commit;
   logic          flush;
   logic          load_main_in;
   logic          load_main_skid;
   logic          load_skid;

   logic [9:0]    main_exc;
   logic          main_ebreak;
   logic          main_ecall;
   logic          main_id_system;

   assign main_exc       = main_reg[EXC_LO +: 10];
   assign main_ebreak    = main_reg[FLOW_LO + 0];
   assign main_ecall     = main_reg[FLOW_LO + 1];
   assign main_id_system = main_reg[FLOW_LO + 5];

   assign ex_ready = ex_ready_reg;
   assign accept   = ex_valid & ex_ready_reg;
   assign wb_valid = (state_reg != EMPTY) & ~hold;
   assign commit   = wb_valid;
   // Flush only counts when something actually commits; hold therefore masks it.
   assign flush    = wb_valid & pip_flush;

   assign int_acc  = wb_valid & int_req & ~(|main_exc) & ~main_id_system;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= EMPTY;
         ex_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         ex_ready_reg <= (state_next != FULL);
      end
   end

   always_comb begin
      state_next     = state_reg;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_next   = ONE;
                  load_main_in = 1'b1;
               end
            end
            ONE: begin
               if (commit) begin
                  if (accept) begin
                     load_main_in = 1'b1;
                  end else begin
                     state_next = EMPTY;
                  end
               end else if (accept) begin
                  state_next = FULL;
                  load_skid  = 1'b1;
               end
            end
            FULL: begin
               if (commit) begin
                  state_next     = ONE;
                  load_main_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_reg <= '0;
         skid_reg <= '0;
      end else begin
         if (load_main_in) begin
            main_reg <= ex_pld;
         end else if (load_main_skid) begin
            main_reg <= skid_reg;
         end
         if (load_skid) begin
            skid_reg <= ex_pld;
         end
      end
   end

   // Control fields (exc/flow/we) are qualified by wb_valid; data, index and PC pass through.
   for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
      assign wb_pld[gi] = main_reg[gi] & wb_valid;
   end
   assign wb_pld[PW-1:CTRL_W] = main_reg[PW-1:CTRL_W];

`ifdef WB_PERF_CNT_EN
   logic [63:0] retire_cnt_reg;
   logic [63:0] trap_cnt_reg;
   logic        retire_inc;
   logic        trap_inc;

   assign retire_inc = wb_valid & ~(|main_exc) & ~main_ecall & ~main_ebreak;
   assign trap_inc   = wb_valid & ((|main_exc) | main_ecall | main_ebreak | int_acc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt_reg <= '0;
         trap_cnt_reg   <= '0;
      end else begin
         if (retire_inc) retire_cnt_reg <= retire_cnt_reg + 64'd1;
         if (trap_inc)   trap_cnt_reg   <= trap_cnt_reg + 64'd1;
      end
   end

   assign retire_cnt = retire_cnt_reg;
   assign trap_cnt   = trap_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage: reset, hold/skid, flush, interrupt accept, output masking.
module tb_wb_commit_stage;

   localparam int DW = 64;
   localparam int VW = 128;
   localparam int AW = 64;
   localparam int PW = 3*DW + VW + 2*AW + 111;

   localparam int OFF_NPC = 111 + AW;
   localparam int OFF_CSR = 111 + 2*AW;
   localparam int OFF_VD  = OFF_CSR + DW;
   localparam int OFF_FD  = OFF_VD + VW;
   localparam int OFF_RD  = OFF_FD + DW;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid;
   logic          ex_ready;
   logic [PW-1:0] ex_pld;
   logic          hold;
   logic          int_req;
   logic          pip_flush;
   logic          wb_valid;
   logic [PW-1:0] wb_pld;
   logic          int_acc;
`ifdef WB_PERF_CNT_EN
   logic [63:0]   retire_cnt;
   logic [63:0]   trap_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_commit_stage #(.DW(DW), .VW(VW), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_valid  (ex_valid),
      .ex_ready  (ex_ready),
      .ex_pld    (ex_pld),
      .hold      (hold),
      .int_req   (int_req),
      .pip_flush (pip_flush),
      .wb_valid  (wb_valid),
      .wb_pld    (wb_pld),
`ifdef WB_PERF_CNT_EN
      .retire_cnt(retire_cnt),
      .trap_cnt  (trap_cnt),
`endif
      .int_acc   (int_acc)
   );

   task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] mkp(input logic [4:0] rd, input logic [9:0] exc,
                                         input logic [5:0] flow, input logic [3:0] we,
                                         input logic [63:0] data_rd, input logic [63:0] new_pc);
      logic [PW-1:0] p;
      p = '0;
      p[9:0]            = exc;
      p[15:10]          = flow;
      p[19:16]          = we;
      p[34:30]          = rd;
      p[OFF_NPC +: AW]  = new_pc;
      p[OFF_RD +: DW]   = data_rd;
      return p;
   endfunction

   function automatic logic [PW-1:0] masked(input logic [PW-1:0] p);
      return {p[PW-1:20], 20'b0};
   endfunction

   // Advance to just after the next rising edge; inputs change here, checks follow after #1.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [PW-1:0] p1, pa, pb, pc, fa, fb, pg, ph, pk, pn, pi, ps;

   initial begin
      p1 = mkp(5'd5, 10'd0, 6'd0, 4'b0010, 64'h1234, 64'd0);
      pa = mkp(5'd1, 10'd0, 6'd0, 4'b0010, 64'hA, 64'd0);
      pb = mkp(5'd2, 10'd0, 6'd0, 4'b0010, 64'hB, 64'd0);
      pc = mkp(5'd3, 10'd0, 6'd0, 4'b0010, 64'hC, 64'd0);
      fa = mkp(5'd0, 10'd0, 6'b010000, 4'b0000, 64'd0, 64'h8000_0100);
      fb = mkp(5'd6, 10'd0, 6'd0, 4'b0010, 64'hFB, 64'd0);
      pg = mkp(5'd7, 10'd0, 6'd0, 4'b0010, 64'h77, 64'd0);
      ph = mkp(5'd8, 10'd0, 6'd0, 4'b0010, 64'h88, 64'd0);
      pk = mkp(5'd9, 10'd0, 6'd0, 4'b0010, 64'h99, 64'd0);
      pn = mkp(5'd10, 10'd0, 6'd0, 4'b0010, 64'hAA, 64'd0);
      pi = mkp(5'd11, 10'b10_0000_0000, 6'd0, 4'b0000, 64'd0, 64'd0);
      ps = mkp(5'd12, 10'd0, 6'b100000, 4'b0001, 64'd0, 64'd0);

      // Reset with ex_valid held high
      rst = 1'b0; ex_valid = 1'b1; ex_pld = p1; hold = 1'b0; int_req = 1'b0; pip_flush = 1'b0;
      tick(); tick();
      check("rst_wb_valid", PW'(wb_valid), PW'(1'b0));
      check("rst_ex_ready", PW'(ex_ready), PW'(1'b1));
      check("rst_wb_pld", wb_pld, '0);
      check("rst_int_acc", PW'(int_acc), PW'(1'b0));
      rst = 1'b1;
      #1 check("post_rel_wb_valid", PW'(wb_valid), PW'(1'b0));
      tick();
      check("first_wb_valid", PW'(wb_valid), PW'(1'b1));
      check("first_wb_pld", wb_pld, p1);
      ex_valid = 1'b0;
      tick();
      check("first_drain_valid", PW'(wb_valid), PW'(1'b0));
      check("first_drain_mask", wb_pld, masked(p1));

      // Hold while streaming A,B,C
      hold = 1'b1; ex_valid = 1'b1; ex_pld = pa;
      tick();
      #1 check("hold1_valid", PW'(wb_valid), PW'(1'b0));
      check("hold1_ready", PW'(ex_ready), PW'(1'b1));
      check("hold1_mask", wb_pld, masked(pa));
      ex_pld = pb;
      tick();
      check("hold2_ready", PW'(ex_ready), PW'(1'b0));
      ex_pld = pc;
      tick();
      check("hold3_ready", PW'(ex_ready), PW'(1'b0));
      hold = 1'b0;
      #1 check("commit_a", wb_pld, pa);
      check("commit_a_valid", PW'(wb_valid), PW'(1'b1));
      tick();
      check("commit_b", wb_pld, pb);
      check("commit_b_ready", PW'(ex_ready), PW'(1'b1));
      tick();
      check("commit_c", wb_pld, pc);
      ex_valid = 1'b0;
      tick();
      check("abc_drained", PW'(wb_valid), PW'(1'b0));

      // Flush from FULL
      hold = 1'b1; ex_valid = 1'b1; ex_pld = fa;
      tick();
      ex_pld = fb;
      tick();
      hold = 1'b0; ex_pld = ph; pip_flush = 1'b1;
      #1 check("flush_commit_a", wb_pld, fa);
      tick();
      pip_flush = 1'b0; ex_valid = 1'b0;
      #1 check("flush_empty_valid", PW'(wb_valid), PW'(1'b0));
      check("flush_empty_ready", PW'(ex_ready), PW'(1'b1));
      tick();
      check("flush_no_skid", PW'(wb_valid), PW'(1'b0));
      // Flush from ONE with a same-cycle accept
      ex_valid = 1'b1; ex_pld = pg;
      tick();
      ex_pld = ph; pip_flush = 1'b1;
      #1 check("flush2_commit_g", wb_pld, pg);
      tick();
      pip_flush = 1'b0; ex_pld = pk;
      #1 check("flush2_drop_h", PW'(wb_valid), PW'(1'b0));
      tick();
      check("flush2_next_k", wb_pld, pk);
      ex_valid = 1'b0;
      tick();

      // Interrupt accept
      int_req = 1'b1; ex_valid = 1'b1; ex_pld = pn;
      tick();
      check("int_normal", PW'(int_acc), PW'(1'b1));
      ex_pld = pi;
      tick();
      check("int_ill", PW'(int_acc), PW'(1'b0));
      check("int_ill_pld", wb_pld, pi);
      ex_pld = ps;
      tick();
      check("int_sys", PW'(int_acc), PW'(1'b0));
      check("int_sys_pld", wb_pld, ps);
      ex_valid = 1'b0;
      tick();
      check("int_idle", PW'(int_acc), PW'(1'b0));
      int_req = 1'b0;

      // Idle flush pulse changes nothing
      pip_flush = 1'b1;
      tick();
      pip_flush = 1'b0;
      #1 check("idle_flush_valid", PW'(wb_valid), PW'(1'b0));
      check("idle_flush_mask", wb_pld, masked(ps));
      // Flush under hold is ignored
      hold = 1'b1; ex_valid = 1'b1; ex_pld = pa;
      tick();
      ex_valid = 1'b0; pip_flush = 1'b1;
      tick();
      hold = 1'b0; pip_flush = 1'b0;
      #1 check("hold_flush_kept", wb_pld, pa);
      check("hold_flush_valid", PW'(wb_valid), PW'(1'b1));
      tick();

      // Reset while FULL drops both entries
      hold = 1'b1; ex_valid = 1'b1; ex_pld = pb;
      tick();
      ex_pld = pc;
      tick();
      rst = 1'b0; ex_valid = 1'b0; hold = 1'b0;
      #1 check("midrst_pld", wb_pld, '0);
      check("midrst_ready", PW'(ex_ready), PW'(1'b1));
      tick();
      rst = 1'b1;
      tick();
      check("midrst_after", PW'(wb_valid), PW'(1'b0));

`ifdef WB_PERF_CNT_EN
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("perf_rst_ret", PW'(retire_cnt), PW'(64'd0));
      check("perf_rst_trap", PW'(trap_cnt), PW'(64'd0));
      ex_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         ex_pld = (i == 4) ? mkp(5'd0, 10'd0, 6'b000010, 4'b0000, 64'd0, 64'd0) : pn;
         tick();
      end
      ex_valid = 1'b0; int_req = 1'b1;
      tick();
      int_req = 1'b0;
      check("perf_retire", PW'(retire_cnt), PW'(64'd5));
      check("perf_trap", PW'(trap_cnt), PW'(64'd2));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
